uart_rx: RTL and testbench

Serial receiver that sits directly downstream of the baud-rate timer. It instantiates `simple_timer` and uses its mid-bit `half` strobe to sample an asynchronous `rxd` line in 8N1 format. It re-phases the timer on every start-bit edge. Each received byte is presented on a one-entry valid/ready output register for the CPU-side UART logic, with sticky framing-error and overrun flags.

---
 rtl/uart_pkg.sv | 18 +
 rtl/simple_timer.sv | 49 ++++
 rtl/uart_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the UART blocks (uart_rx now, uart_tx later).
//   uart_rx_state_t : receiver FSM state encoding
//   UART_DATA_BITS  : data bits per frame (8N1 format)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/simple_timer.sv
// -----------------------------------------------------------------------------
// simple_timer
// Free-running bit-period timer. The count is held at 0 while rst is high and
// starts counting the cycle after rst falls, wrapping every PERIOD cycles.
//   clk  : system clock
//   rst  : synchronous active-high reset / re-phase request
//   full : count is at PERIOD-1 (last cycle of a bit period)
//   half : count is at PERIOD>>1 (middle of a bit period)
// -----------------------------------------------------------------------------
module simple_timer #(
    parameter int PERIOD = 27_000_000 / 9600,
    parameter int BITS   = 24
) (
    input  logic clk,
    input  logic rst,
    output logic full,
    output logic half
);

    localparam logic [BITS-1:0] LAST_CNT = BITS'(PERIOD - 1);
    localparam logic [BITS-1:0] HALF_CNT = BITS'(PERIOD >> 1);

    logic [BITS-1:0] count_r;

    // Bit-period counter: held at zero in reset, wraps after PERIOD cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {BITS{1'b0}};
        end else if (count_r == LAST_CNT) begin
            count_r <= {BITS{1'b0}};
        end else begin
            count_r <= count_r + {{(BITS-1){1'b0}}, 1'b1};
        end
    end

    // Strobe decode from the registered count; suppressed while held in reset.
    always_comb begin
        full = 1'b0;
        half = 1'b0;
        if (!rst) begin
            full = (count_r == LAST_CNT);
            half = (count_r == HALF_CNT);
        end else begin
            full = 1'b0;
            half = 1'b0;
        end
    end

endmodule : simple_timer

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver. The asynchronous rxd line is synchronised, a falling
// edge in IDLE re-phases the bit timer, and each bit is sampled on the timer's
// mid-bit strobe. Received bytes land in a one-entry valid/ready holding
// register; sticky flags report framing errors and overruns.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   rxd       : serial input, idle high
//   rx_data   : received byte, valid while rx_valid
//   rx_valid  : holding register full
//   rx_ready  : consumer pops the byte when rx_valid && rx_ready
//   frame_err : sticky, stop bit sampled low
//   overrun   : sticky, byte arrived while holding register full and not popped
//   err_clr   : one-cycle pulse clearing both sticky flags
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int PERIOD = 27_000_000 / 9600,
    parameter int BITS   = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      overrun,
    input  logic                      err_clr
);

    localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

    // Synchroniser and edge detector
    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic fall_s;

    // FSM and datapath
    uart_rx_state_t            state_r;
    uart_rx_state_t            state_s;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic [UART_DATA_BITS-1:0] shift_s;
    logic [2:0]                idx_r;
    logic [2:0]                idx_s;
    logic                      deliver_s;
    logic                      ferr_set_s;

    // Holding register and flags
    logic [UART_DATA_BITS-1:0] rx_data_r;
    logic [UART_DATA_BITS-1:0] rx_data_s;
    logic                      rx_valid_r;
    logic                      rx_valid_s;
    logic                      frame_err_r;
    logic                      frame_err_s;
    logic                      overrun_r;
    logic                      overrun_s;
    logic                      pop_s;

    // Timer control
    logic timer_rst_r;
    logic timer_rst_s;
    logic half_s;
    logic timer_full_unused;

    // The timer has only a synchronous reset, so system reset is folded in
    // here to keep it parked at zero while rst_n is low.
    assign timer_rst_s = timer_rst_r | ~rst_n;

    simple_timer #(
        .PERIOD (PERIOD),
        .BITS   (BITS)
    ) u_timer (
        .clk  (clk),
        .rst  (timer_rst_s),
        .full (timer_full_unused),
        .half (half_s)
    );

    assign fall_s = prev_r & ~sync2_r;

    // Two-stage synchroniser for rxd plus the edge-detect history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rxd;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // FSM state register; the timer is held in reset exactly while in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            timer_rst_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            timer_rst_r <= (state_s == IDLE);
        end
    end

    // Next-state, bit sampling and delivery/error event decode.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        idx_s      = idx_r;
        deliver_s  = 1'b0;
        ferr_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (half_s) begin
                    // A line back high at mid start bit was a glitch.
                    if (sync2_r) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DATA;
                        idx_s   = 3'd0;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (half_s) begin
                    shift_s = {sync2_r, shift_r[UART_DATA_BITS-1:1]};
                    if (idx_r == LAST_IDX) begin
                        state_s = STOP;
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                // Leaving at mid stop bit lets a back-to-back start edge be
                // seen half a bit later.
                if (half_s) begin
                    state_s = IDLE;
                    if (sync2_r) begin
                        deliver_s = 1'b1;
                    end else begin
                        ferr_set_s = 1'b1;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Shift register and bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {UART_DATA_BITS{1'b0}};
            idx_r   <= 3'd0;
        end else begin
            shift_r <= shift_s;
            idx_r   <= idx_s;
        end
    end

    assign pop_s = rx_valid_r & rx_ready;

    // Holding register and sticky flag update; set events win over err_clr.
    always_comb begin
        rx_data_s   = rx_data_r;
        rx_valid_s  = rx_valid_r;
        frame_err_s = frame_err_r;
        overrun_s   = overrun_r;

        if (err_clr) begin
            frame_err_s = 1'b0;
            overrun_s   = 1'b0;
        end else begin
            frame_err_s = frame_err_r;
            overrun_s   = overrun_r;
        end

        if (ferr_set_s) begin
            frame_err_s = 1'b1;
        end else begin
            frame_err_s = frame_err_s;
        end

        if (deliver_s) begin
            // A pop in the same cycle frees the slot for the new byte.
            if (!rx_valid_r || pop_s) begin
                rx_data_s  = shift_r;
                rx_valid_s = 1'b1;
            end else begin
                overrun_s = 1'b1;
            end
        end else if (pop_s) begin
            rx_valid_s = 1'b0;
        end else begin
            rx_valid_s = rx_valid_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_r   <= {UART_DATA_BITS{1'b0}};
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            rx_data_r   <= rx_data_s;
            rx_valid_r  <= rx_valid_s;
            frame_err_r <= frame_err_s;
            overrun_r   <= overrun_s;
        end
    end

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx with PERIOD=16. Expected bytes are queued
// when a frame is sent; a monitor logs every byte the consumer accepts, and
// each scenario task compares the two queues plus output levels/flags.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int PERIOD = 16;
    localparam int BITS   = 24;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rxd      = 1'b1;
    logic       rx_ready = 1'b0;
    logic       err_clr  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int checks      = 0;
    int errors      = 0;
    int valid_rises = 0;
    logic valid_prev = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    uart_rx #(
        .PERIOD (PERIOD),
        .BITS   (BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Monitor: just after each falling edge, log accepted bytes and count
    // rising edges of rx_valid.
    always @(negedge clk) begin
        #1;
        if (rx_valid && !valid_prev) valid_rises <= valid_rises + 1;
        valid_prev <= rx_valid;
        if (rx_valid && rx_ready) obs_q.push_back(rx_data);
    end

    // Drives one 8N1 frame; must be called right at a falling edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (PERIOD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (PERIOD) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (PERIOD) @(negedge clk);
        rxd = 1'b1;
    endtask

    // Bounded wait for the monitor to log an accepted byte.
    task automatic wait_obs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (obs_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_frame();
        bit ok;
        int r0;
        logic [7:0] got, want;
        rx_ready = 1'b1;
        r0 = valid_rises;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        send_frame(8'hA5, 1'b1);
        repeat (5) @(negedge clk);
        wait_obs(ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++; $display("FAIL single_data: got no byte want a5");
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin errors++; $display("FAIL single_data: got %h want %h", got, want); end
        end
        checks++; if (valid_rises - r0 != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", valid_rises - r0); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL single_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL single_ovr: got %b want 0", overrun); end
    endtask

    task automatic test_glitch();
        bit ok;
        int r0;
        logic [7:0] got, want;
        r0 = valid_rises;
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL glitch_ovr: got %b want 0", overrun); end
        checks++; if (valid_rises != r0 || obs_q.size() != 0) begin errors++; $display("FAIL glitch_nobyte: got %0d pulses want 0", valid_rises - r0); end
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        repeat (5) @(negedge clk);
        wait_obs(ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++; $display("FAIL glitch_next: got no byte want 01");
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin errors++; $display("FAIL glitch_next: got %h want %h", got, want); end
        end
    endtask

    task automatic test_frame_err();
        bit ok;
        logic [7:0] got, want;
        @(negedge clk);
        send_frame(8'h55, 1'b0);
        repeat (5) @(negedge clk);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b want 1", frame_err); end
        checks++; if (rx_valid !== 1'b0 || obs_q.size() != 0) begin errors++; $display("FAIL ferr_discard: got valid %b want 0", rx_valid); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        repeat (5) @(negedge clk);
        wait_obs(ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++; $display("FAIL ferr_next: got no byte want 0f");
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin errors++; $display("FAIL ferr_next: got %h want %h", got, want); end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        logic [7:0] got, want;
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);   // 0x22 is dropped, never popped
        @(negedge clk);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (5) @(negedge clk);
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_keep: got %h want 11", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_pop: got %b want 0", rx_valid); end
        wait_obs(ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++; $display("FAIL ovr_popdata: got no byte want 11");
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin errors++; $display("FAIL ovr_popdata: got %h want %h", got, want); end
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_pop_with_delivery();
        bit ok;
        logic [7:0] got, want;
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        @(negedge clk);
        send_frame(8'h11, 1'b1);
        // Stop-bit mid-sample is 155 cycles after the start edge, so the
        // delivery edge samples rx_ready driven at falling edge 155.
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (155) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL popdel_data: got %h want 22", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL popdel_valid: got %b want 1", rx_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL popdel_ovr: got %b want 0", overrun); end
        wait_obs(ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++; $display("FAIL popdel_popped: got no byte want 11");
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin errors++; $display("FAIL popdel_popped: got %h want %h", got, want); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int r0;
        logic [7:0] pat;
        logic [7:0] got, want;
        pat = 8'h96;
        @(negedge clk);
        rxd = 1'b0;
        repeat (PERIOD) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = pat[i];
            repeat (PERIOD) @(negedge clk);
        end
        rxd = pat[3];
        repeat (PERIOD / 2) @(negedge clk);
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_ovr: got %b want 0", overrun); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        rx_ready = 1'b1;
        r0 = valid_rises;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (5) @(negedge clk);
        wait_obs(ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++; $display("FAIL midrst_next: got no byte want 3c");
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin errors++; $display("FAIL midrst_next: got %h want %h", got, want); end
        end
        checks++; if (valid_rises - r0 != 1) begin errors++; $display("FAIL midrst_pulses: got %0d want 1", valid_rises - r0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_pop_with_delivery();
        test_reset_mid_frame();
        checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d unmatched bytes want 0", obs_q.size() + exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx
